// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One trial subtraction per cycle, XLEN cycles per operation plus one cycle to
// sign-fix and register the result. Valid/ready handshake on both sides.
// Optional build macro: DIV_EARLY_OUT_EN -- divide-by-zero and signed overflow
// skip the iteration loop and complete one edge after the accept edge.
module seq_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  // Two's complement negation in XLEN bits.
  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
    return ~x + XLEN'(1);
  endfunction

  logic [1:0]      state, state_next;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] rem, quo, dvs, a_q;
  logic [1:0]      op_q;
  logic            sign_a, sign_b, div_zero, ovf;

  logic            accept_c;
  logic            signed_in_c;
  logic            b_zero_c;
  logic            ovf_in_c;
  logic            early_c;
  logic [XLEN:0]   rem_sh_c;
  logic [XLEN:0]   trial_c;
  logic [XLEN-1:0] final_c;

  // Accept conditions and corner-case detection on the incoming request.
  always_comb begin
    accept_c    = (state == S_IDLE) && in_valid;
    signed_in_c = ~op[0];
    b_zero_c    = (b == '0);
    ovf_in_c    = signed_in_c && (a == MIN_NEG) && (b == ALL_ONES);
    early_c     = EARLY_OUT && (b_zero_c || ovf_in_c);
  end

  // One restoring step: shift in next dividend bit and trial-subtract divisor.
  always_comb begin
    rem_sh_c = {rem, quo[XLEN-1]};
    trial_c  = rem_sh_c - {1'b0, dvs};
  end

  // Sign-fix the raw quotient/remainder and apply the RISC-V corner results.
  always_comb begin
    final_c = '0;
    if (div_zero) begin
      final_c = op_q[1] ? a_q : ALL_ONES;
    end else if (ovf) begin
      final_c = op_q[1] ? '0 : MIN_NEG;
    end else if (op_q[1]) begin
      final_c = sign_a ? neg(rem) : rem;
    end else begin
      final_c = (sign_a ^ sign_b) ? neg(quo) : quo;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept_c) begin
          state_next = early_c ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (count == CW'(XLEN - 1)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_valid && out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Registered handshake status derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      in_ready <= (state_next == S_IDLE);
      busy     <= (state_next != S_IDLE);
    end
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      a_q      <= '0;
      op_q     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else if (accept_c) begin
      op_q     <= op;
      sign_a   <= signed_in_c & a[XLEN-1];
      sign_b   <= signed_in_c & b[XLEN-1];
      a_q      <= a;
      div_zero <= b_zero_c;
      ovf      <= ovf_in_c;
      dvs      <= (signed_in_c & b[XLEN-1]) ? neg(b) : b;
      quo      <= (signed_in_c & a[XLEN-1]) ? neg(a) : a;
      rem      <= '0;
      count    <= '0;
    end else if (state == S_RUN) begin
      rem   <= trial_c[XLEN] ? rem_sh_c[XLEN-1:0] : trial_c[XLEN-1:0];
      quo   <= {quo[XLEN-2:0], ~trial_c[XLEN]};
      count <= count + CW'(1);
    end
  end

  // Result register: loaded on the first DONE cycle, held until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (state == S_DONE) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        result    <= final_c;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
